// File: rtl/tlb_cp0_reader_if.sv
// tlb_cp0_reader_if
//   CP0-side request/response bus of the TLB reader.
//   Request : req_valid/req_ready handshake with req_op (0=TLBR, 1=TLBP),
//             req_index (TLBR entry), req_vpn2 / req_asid (TLBP key).
//   Response: resp_valid one-cycle pulse with resp_op, resp_entryhi,
//             resp_entrylo0, resp_entrylo1 and resp_index; the data fields
//             hold their values until the next response.
//   master : the CP0 requester; slave : the tlb_cp0_reader.
interface tlb_cp0_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [3:0]  req_index;
    logic [18:0] req_vpn2;
    logic [7:0]  req_asid;

    logic        resp_valid;
    logic        resp_op;
    logic [31:0] resp_entryhi;
    logic [31:0] resp_entrylo0;
    logic [31:0] resp_entrylo1;
    logic [31:0] resp_index;

    modport master (
        output req_valid, req_op, req_index, req_vpn2, req_asid,
        input  req_ready,
        input  resp_valid, resp_op, resp_entryhi, resp_entrylo0,
               resp_entrylo1, resp_index
    );

    modport slave (
        input  req_valid, req_op, req_index, req_vpn2, req_asid,
        output req_ready,
        output resp_valid, resp_op, resp_entryhi, resp_entrylo0,
               resp_entrylo1, resp_index
    );
endinterface

// File: rtl/tlb_cp0_reader.sv
// tlb_cp0_reader
//   Services CP0 TLBR (read indexed entry) and TLBP (probe) requests against
//   a 16-entry TLB array with a one-cycle registered read port.
//   Ports:
//     clk           clock, all state changes on the rising edge
//     rst           synchronous active-high reset
//     cp0           request/response bus (slave side)
//     flush         abort the current operation without a response
//     entry_rd_idx  TLB array read address (always idx_q)
//     entry_rd_data entry addressed by entry_rd_idx on the previous cycle
//                   {ASID, G, VPN2, PFN1, D1, V1, PFN0, D0, V0}
//     busy          high whenever a request cannot be accepted
module tlb_cp0_reader (
    input  logic                    clk,
    input  logic                    rst,
    tlb_cp0_reader_if.slave         cp0,
    input  logic                    flush,
    output logic [3:0]              entry_rd_idx,
    input  logic [79:0]             entry_rd_data,
    output logic                    busy
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        PROBE,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  idx_q;
    logic        op_q;
    logic [18:0] vpn2_q;
    logic [7:0]  asid_q;

    logic        resp_valid_q;
    logic        resp_op_q;
    logic [31:0] resp_entryhi_q;
    logic [31:0] resp_entrylo0_q;
    logic [31:0] resp_entrylo1_q;
    logic [31:0] resp_index_q;

    // Unpacked view of the entry returned by the array.
    logic [7:0]  e_asid;
    logic        e_g;
    logic [18:0] e_vpn2;
    logic [23:0] e_pfn1;
    logic        e_d1;
    logic        e_v1;
    logic [23:0] e_pfn0;
    logic        e_d0;
    logic        e_v0;

    // During PROBE idx_q already points one ahead of the entry whose data
    // is on entry_rd_data, so the entry under comparison is idx_q-1.
    logic [3:0]  cmp_idx;
    logic        probe_hit;

    always_comb begin
        e_asid    = entry_rd_data[79:72];
        e_g       = entry_rd_data[71];
        e_vpn2    = entry_rd_data[70:52];
        e_pfn1    = entry_rd_data[51:28];
        e_d1      = entry_rd_data[27];
        e_v1      = entry_rd_data[26];
        e_pfn0    = entry_rd_data[25:2];
        e_d0      = entry_rd_data[1];
        e_v0      = entry_rd_data[0];
        cmp_idx   = idx_q - 4'd1;
        probe_hit = (e_vpn2 == vpn2_q) && (e_g || (e_asid == asid_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx_q           <= '0;
            op_q            <= 1'b0;
            vpn2_q          <= '0;
            asid_q          <= '0;
            resp_valid_q    <= 1'b0;
            resp_op_q       <= 1'b0;
            resp_entryhi_q  <= '0;
            resp_entrylo0_q <= '0;
            resp_entrylo1_q <= '0;
            resp_index_q    <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cp0.req_valid && !flush) begin
                        op_q   <= cp0.req_op;
                        vpn2_q <= cp0.req_vpn2;
                        asid_q <= cp0.req_asid;
                        idx_q  <= cp0.req_op ? 4'd0 : cp0.req_index;
                        state  <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (op_q) begin
                        // Entry 0 is being read now; advance so entry 1
                        // is requested while entry 0 is compared.
                        idx_q <= idx_q + 4'd1;
                        state <= PROBE;
                    end else begin
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        resp_op_q       <= 1'b0;
                        resp_entryhi_q  <= {e_vpn2, 5'b0, e_asid};
                        resp_entrylo0_q <= {2'b0, e_pfn0, 3'b0, e_d0, e_v0, e_g};
                        resp_entrylo1_q <= {2'b0, e_pfn1, 3'b0, e_d1, e_v1, e_g};
                        resp_index_q    <= {28'b0, idx_q};
                        resp_valid_q    <= 1'b1;
                        state           <= RESP;
                    end
                end

                PROBE: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                        if (probe_hit) begin
                            resp_op_q    <= 1'b1;
                            resp_index_q <= {28'b0, cmp_idx};
                            resp_valid_q <= 1'b1;
                            state        <= RESP;
                        end else if (cmp_idx == 4'hF) begin
                            resp_op_q    <= 1'b1;
                            resp_index_q <= 32'h8000_0000;
                            resp_valid_q <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign entry_rd_idx      = idx_q;
    assign cp0.req_ready     = (state == IDLE);
    assign busy              = (state != IDLE);
    assign cp0.resp_valid    = resp_valid_q;
    assign cp0.resp_op       = resp_op_q;
    assign cp0.resp_entryhi  = resp_entryhi_q;
    assign cp0.resp_entrylo0 = resp_entrylo0_q;
    assign cp0.resp_entrylo1 = resp_entrylo1_q;
    assign cp0.resp_index    = resp_index_q;

endmodule

// File: tb/tb_tlb_cp0_reader.sv
// tb_tlb_cp0_reader
//   Directed bench for tlb_cp0_reader: TLBR unpacking, TLBP hit / lowest
//   index / miss / last-entry hit, flush and reset aborts. A behavioural
//   16-entry TLB array with a registered read port feeds entry_rd_data.
module tb_tlb_cp0_reader;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [3:0]  entry_rd_idx;
    logic [79:0] entry_rd_data;
    logic        busy;

    logic [79:0] tlb [16];

    int compared;
    int mismatched;

    tlb_cp0_reader_if cp0 ();

    tlb_cp0_reader dut (
        .clk           (clk),
        .rst           (rst),
        .cp0           (cp0),
        .flush         (flush),
        .entry_rd_idx  (entry_rd_idx),
        .entry_rd_data (entry_rd_data),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) entry_rd_data <= tlb[entry_rd_idx];

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    function automatic logic [79:0] mk(input logic [7:0] asid, input logic g,
                                       input logic [18:0] vpn2,
                                       input logic [23:0] pfn1, input logic d1, input logic v1,
                                       input logic [23:0] pfn0, input logic d0, input logic v0);
        return {asid, g, vpn2, pfn1, d1, v1, pfn0, d0, v0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; lat counts cycles from acceptance
    // until resp_valid is seen (bounded). seq collects entry_rd_idx for the
    // first 16 cycles after acceptance.
    task automatic run_req(input logic op, input logic [3:0] index,
                           input logic [18:0] vpn2, input logic [7:0] asid,
                           output int lat, output logic [63:0] seq);
        cp0.req_valid = 1'b1;
        cp0.req_op    = op;
        cp0.req_index = index;
        cp0.req_vpn2  = vpn2;
        cp0.req_asid  = asid;
        seq = '0;
        step();
        cp0.req_valid = 1'b0;
        lat = 1;
        while (cp0.resp_valid !== 1'b1 && lat < 40) begin
            if (lat <= 16) seq = {seq[59:0], entry_rd_idx};
            step();
            lat++;
        end
    endtask

    int          lat;
    logic [63:0] seq;

    initial begin
        compared      = 0;
        mismatched    = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        cp0.req_valid = 1'b0;
        cp0.req_op    = 1'b0;
        cp0.req_index = '0;
        cp0.req_vpn2  = '0;
        cp0.req_asid  = '0;

        for (int i = 0; i < 16; i++)
            tlb[i] = mk(8'hAA, 1'b0, 19'h70000 | 19'(i), 24'h100000 | 24'(i), 1'b0, 1'b1,
                        24'h200000 | 24'(i), 1'b1, 1'b0);
        tlb[5]  = mk(8'h3C, 1'b0, 19'h12345, 24'hABCDE, 1'b1, 1'b1, 24'h11111, 1'b0, 1'b1);
        tlb[3]  = mk(8'h06, 1'b0, 19'h00010, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
        tlb[9]  = mk(8'h05, 1'b0, 19'h00010, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
        tlb[12] = mk(8'h77, 1'b1, 19'h00010, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
        tlb[7]  = mk(8'h01, 1'b0, 19'h00020, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
        tlb[14] = mk(8'h02, 1'b0, 19'h00020, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
        tlb[15] = mk(8'h42, 1'b0, 19'h00030, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);

        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_resp_valid", 64'(cp0.resp_valid), 64'h0);
        chk("rst_req_ready",  64'(cp0.req_ready),  64'h1);
        chk("rst_busy",       64'(busy),           64'h0);
        chk("rst_rd_idx",     64'(entry_rd_idx),   64'h0);
        chk("rst_entryhi",    64'(cp0.resp_entryhi), 64'h0);
        chk("rst_index",      64'(cp0.resp_index),   64'h0);

        // TLBR index 5
        run_req(1'b0, 4'd5, 19'h0, 8'h0, lat, seq);
        chk("tlbr_latency",  64'(lat), 64'd3);
        chk("tlbr_op",       64'(cp0.resp_op),       64'h0);
        chk("tlbr_entryhi",  64'(cp0.resp_entryhi),  64'h2468_A03C);
        chk("tlbr_entrylo0", 64'(cp0.resp_entrylo0), 64'h0044_4442);
        chk("tlbr_entrylo1", 64'(cp0.resp_entrylo1), 64'h02AF_3786);
        chk("tlbr_index",    64'(cp0.resp_index),    64'h0000_0005);
        step();
        chk("tlbr_pulse_end", 64'(cp0.resp_valid), 64'h0);
        chk("tlbr_ready_again", 64'(cp0.req_ready), 64'h1);
        chk("tlbr_hold_entryhi", 64'(cp0.resp_entryhi), 64'h2468_A03C);

        // TLBP hit at 9 (entry 12 also matches via G, entry 3 differs by ASID)
        run_req(1'b1, 4'd0, 19'h00010, 8'h05, lat, seq);
        chk("tlbp_hit_latency",  64'(lat), 64'd12);
        chk("tlbp_hit_op",       64'(cp0.resp_op),       64'h1);
        chk("tlbp_hit_index",    64'(cp0.resp_index),    64'h0000_0009);
        chk("tlbp_hit_entryhi",  64'(cp0.resp_entryhi),  64'h2468_A03C);
        chk("tlbp_hit_entrylo0", 64'(cp0.resp_entrylo0), 64'h0044_4442);
        chk("tlbp_hit_entrylo1", 64'(cp0.resp_entrylo1), 64'h02AF_3786);
        step();

        // TLBP miss: VPN2 present at 7 and 14 but ASID differs, G=0
        run_req(1'b1, 4'd0, 19'h00020, 8'h03, lat, seq);
        chk("tlbp_miss_latency", 64'(lat), 64'd18);
        chk("tlbp_miss_index",   64'(cp0.resp_index), 64'h8000_0000);
        chk("tlbp_miss_sweep",   seq, 64'h0123_4567_89AB_CDEF);
        step();

        // TLBP only entry 15 matches
        run_req(1'b1, 4'd0, 19'h00030, 8'h42, lat, seq);
        chk("tlbp_last_latency", 64'(lat), 64'd18);
        chk("tlbp_last_index",   64'(cp0.resp_index), 64'h0000_000F);
        step();

        // flush in IDLE blocks acceptance
        cp0.req_valid = 1'b1;
        cp0.req_op    = 1'b0;
        cp0.req_index = 4'd5;
        flush         = 1'b1;
        step();
        cp0.req_valid = 1'b0;
        flush         = 1'b0;
        chk("flush_idle_ready", 64'(cp0.req_ready), 64'h1);
        step();
        step();
        step();
        chk("flush_idle_no_resp", 64'(cp0.resp_valid), 64'h0);

        // flush during PROBE at T+6, then TLBR at T+7
        cp0.req_valid = 1'b1;
        cp0.req_op    = 1'b1;
        cp0.req_vpn2  = 19'h00020;
        cp0.req_asid  = 8'h03;
        step();                 // T+1
        cp0.req_valid = 1'b0;
        step();                 // T+2
        step();                 // T+3
        step();                 // T+4
        step();                 // T+5
        chk("probe_busy",      64'(busy),          64'h1);
        chk("probe_not_ready", 64'(cp0.req_ready), 64'h0);
        chk("probe_rd_idx",    64'(entry_rd_idx),  64'h4);
        step();                 // T+6
        flush = 1'b1;
        step();                 // T+7
        flush = 1'b0;
        chk("flush_probe_no_resp", 64'(cp0.resp_valid), 64'h0);
        chk("flush_probe_ready",   64'(cp0.req_ready),  64'h1);
        run_req(1'b0, 4'd9, 19'h0, 8'h0, lat, seq);
        chk("after_flush_latency", 64'(lat), 64'd3);
        chk("after_flush_entryhi", 64'(cp0.resp_entryhi), 64'h0002_0005);
        chk("after_flush_index",   64'(cp0.resp_index),   64'h0000_0009);
        step();

        // rst in CAPTURE of a TLBR
        cp0.req_valid = 1'b1;
        cp0.req_op    = 1'b0;
        cp0.req_index = 4'd5;
        step();                 // T+1 ISSUE
        cp0.req_valid = 1'b0;
        step();                 // T+2 CAPTURE
        rst = 1'b1;
        step();                 // T+3
        rst = 1'b0;
        chk("rst_cap_resp_valid", 64'(cp0.resp_valid),    64'h0);
        chk("rst_cap_entryhi",    64'(cp0.resp_entryhi),  64'h0);
        chk("rst_cap_entrylo0",   64'(cp0.resp_entrylo0), 64'h0);
        chk("rst_cap_entrylo1",   64'(cp0.resp_entrylo1), 64'h0);
        chk("rst_cap_index",      64'(cp0.resp_index),    64'h0);
        chk("rst_cap_ready",      64'(cp0.req_ready),     64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tlb_cp0_reader.md
TLB_CP0_READER -- requirements
Module: tlb_cp0_reader

Interface
REQ-001 The module SHALL have these ports: clk  in  1  clock; all state changes on rising edge.
REQ-002 The module SHALL have these ports: rst  in  1  reset, synchronous and active-high.
REQ-003 The module SHALL have these ports: req_valid  in  1  CP0 request strobe.
REQ-004 The module SHALL have these ports: req_ready  out  1  high only in IDLE; a request is accepted on req_valid&&req_ready.
REQ-005 The module SHALL have these ports: req_op  in  1  0=TLBR (read entry), 1=TLBP (probe).
REQ-006 The module SHALL have these ports: req_index  in  4  TLBR target entry.
REQ-007 The module SHALL have these ports: req_vpn2  in  19  TLBP virtual page pair.
REQ-008 The module SHALL have these ports: req_asid  in  8  TLBP address-space ID.
REQ-009 The module SHALL have these ports: flush  in  1  abort the current operation, no response.
REQ-010 The module SHALL have these ports: entry_rd_idx  out  4  TLB array read address.
REQ-011 The module SHALL have these ports: entry_rd_data  in  80  entry at the entry_rd_idx presented on the previous cycle; layout {ASID[79:72], G[71], VPN2[70:52], PFN1[51:28], D1[27], V1[26], PFN0[25:2], D0[1], V0[0]}.
REQ-012 The module SHALL have these ports: resp_valid  out  1  one-cycle response pulse.
REQ-013 The module SHALL have these ports: resp_op  out  1  op of the response.
REQ-014 The module SHALL have these ports: resp_entryhi  out  32  {VPN2, 5'b0, ASID}.
REQ-015 The module SHALL have these ports: resp_entrylo0  out  32  {2'b0, PFN0, 3'b0, D0, V0, G}.
REQ-016 The module SHALL have these ports: resp_entrylo1  out  32  {2'b0, PFN1, 3'b0, D1, V1, G}.
REQ-017 The module SHALL have these ports: resp_index  out  32  {P, 27'b0, idx[3:0]}; P=1 means probe miss.
REQ-018 The module SHALL have these ports: busy  out  1  equals ~req_ready.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, CAPTURE, PROBE and RESP.
REQ-020 On accepting a request, the module SHALL latch op, index, vpn2 and asid, and set idx_q to req_index for TLBR or to 0 for TLBP.
REQ-021 entry_rd_idx SHALL equal idx_q in every state; idx_q SHALL hold its value in IDLE.
REQ-022 TLBR: accepted at cycle T -> ISSUE at T+1 -> CAPTURE at T+2, where entry_rd_data is unpacked into the resp_* registers -> RESP at T+3 with resp_valid=1, resp_op=0, resp_index={1'b0, 27'b0, idx}.
REQ-023 TLBP: from ISSUE the FSM SHALL enter PROBE; each cycle, idx_q increments and the data for idx_q-1 is compared, so entry k is compared at cycle T+2+k.
REQ-024 A TLBP match SHALL require (VPN2 == vpn2_q) && (G || ASID == asid_q).
REQ-025 On the first match at index k, the module SHALL stop scanning, load resp_index={0, 27'b0, k}, and hold resp_entry* unchanged; resp_valid SHALL be asserted at T+3+k.
REQ-026 If multiple entries match, the module SHALL report the lowest index.
REQ-027 If there is no match after entry 15 is compared (idx_q wraps 15->0 and is not used further), the module SHALL report resp_index=32'h8000_0000 with resp_valid at T+18.
REQ-028 RESP SHALL last exactly one cycle, then return to IDLE; req_ready is 0 in RESP, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-029 resp_* registers other than resp_valid SHALL hold their values until overwritten by the next response.
REQ-030 flush in any non-IDLE state SHALL cause a return to IDLE on the next edge with no resp_valid; flush in RESP SHALL not suppress the pulse already present; flush in IDLE SHALL block acceptance in that cycle.
REQ-031 req_valid outside IDLE SHALL be ignored, and the request is not queued.
REQ-032 Entry contents changing during a probe SHALL be used as sampled; no coherence is provided.

Reset
REQ-033 When rst is high at a rising edge, the module SHALL enter IDLE and clear idx_q and all resp_* outputs to 0, so resp_valid=0, busy=0 and req_ready=1 after reset.
REQ-034 rst mid-operation SHALL abort the operation with no response; rst SHALL take priority over flush and req_valid.

Verification
REQ-035 TLBR index 5, entry {ASID=8'h3C, G=0, VPN2=19'h12345, PFN1=24'hABCDE, D1=1, V1=1, PFN0=24'h11111, D0=0, V0=1} -> resp_valid 3 cycles after accept; entryhi=32'h2468_A03C, entrylo0=32'h0044_4442, entrylo1=32'h02AF_3786, index=32'h0000_0005.
REQ-036 TLBP vpn2=19'h00010, asid=8'h05, matching entry 9 (ASID 05, G=0) plus entry 12 (G=1, same VPN2) -> index=32'h0000_0009 at T+12; entry* regs unchanged.
REQ-037 TLBP with ASID mismatch at all entries and G=0 -> index=32'h8000_0000 at T+18; entry_rd_idx sweeps 0..15.
REQ-038 TLBP where only entry 15 matches -> index=32'h0000_000F at T+18.
REQ-039 flush during PROBE at T+6 -> no resp_valid, req_ready=1 at T+7; a new TLBR issued at T+7 responds at T+10.
REQ-040 rst asserted in CAPTURE of a TLBR -> no resp_valid, all resp_* equal 0 next cycle.
